// File: rtl/oka_93bit_seq_if.sv
// oka_93bit_seq_if
//   Operand/result bundle for the sequenced 93-bit GF(2) multiplier.
//   master : requester side (drives start, a, b; observes busy, done, y)
//   slave  : multiplier side (observes start, a, b; drives busy, done, y)
// Signals:
//   start  request, sampled by the multiplier only while it is not busy
//   a, b   93-bit operands, bit i = coefficient of x^i
//   busy   multiplication in progress
//   done   one-cycle pulse, y holds a fresh product
//   y      185-bit product, held until the next product or reset
interface oka_93bit_seq_if;
  logic         start;
  logic [92:0]  a;
  logic [92:0]  b;
  logic         busy;
  logic         done;
  logic [184:0] y;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input y);
  modport slave  (input  start, input  a, input  b,
                  output busy,  output done, output y);
endinterface

// File: rtl/oka_93bit_seq.sv
// oka_93bit_seq
//   Sequenced 93-bit GF(2) polynomial multiplier. Operands are split into
//   even/odd coefficient halves (47 bits each) and a single 47x47 core is
//   reused for the three sub-products:
//     P1 = Ea*Eb, P2 = Oa*Ob, P3 = (Ea^Oa)*(Eb^Ob)
//   The product is rebuilt as
//     y[2i]   = P1[i] ^ P2[i-1]
//     y[2i+1] = P1[i] ^ P2[i] ^ P3[i]
//   and registered into y on the final pass.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   oka_93bit_seq_if.slave (start, a, b in; busy, done, y out)
// Configuration macro:
//   OKA_SEQ_CORE_REG_EN  registers the core output; adds a FLUSH state so
//                        latency becomes 5 cycles instead of 4.
module oka_93bit_seq (
  input  logic              clk,
  input  logic              rst,
  oka_93bit_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_M1    = 3'd1,
    ST_M2    = 3'd2,
    ST_M3    = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] SEL_E = 2'd0;
  localparam logic [1:0] SEL_O = 2'd1;
  localparam logic [1:0] SEL_S = 2'd2;

  // 47x47 carry-less product; the one shared multiplier core.
  function automatic logic [92:0] oka_47bit(input logic [46:0] x, input logic [46:0] z);
    logic [92:0] acc;
    acc = 93'd0;
    for (int i = 0; i < 47; i++) begin
      acc = acc ^ (({46'd0, x} << i) & {93{z[i]}});
    end
    return acc;
  endfunction

  // Odd/even overlap recombination of the three sub-products.
  function automatic logic [184:0] recombine(input logic [92:0] p1,
                                             input logic [91:0] p2,
                                             input logic [92:0] p3);
    logic [184:0] r;
    r = 185'd0;
    r[0] = p1[0];
    for (int i = 1; i <= 92; i++) begin
      r[2*i] = p1[i] ^ p2[i-1];
    end
    for (int i = 0; i <= 91; i++) begin
      r[2*i+1] = p1[i] ^ p2[i] ^ p3[i];
    end
    return r;
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [92:0]   a_r;
  logic [92:0]   b_r;
  logic [92:0]   p1_r;
  // Oa[46] = Ob[46] = 0, so the x^92 term of P2 is always zero and not stored.
  logic [91:0]   p2_r;
  logic [184:0]  y_r;
  logic          busy_r;
  logic          done_r;

  logic          cap_en_s;
  logic [1:0]    op_sel_s;
  logic          p1_en_s;
  logic          p2_en_s;
  logic          y_en_s;
  logic          busy_nxt_s;
  logic          done_nxt_s;
  logic [46:0]   ea_s;
  logic [46:0]   oa_s;
  logic [46:0]   eb_s;
  logic [46:0]   ob_s;
  logic [46:0]   core_x_s;
  logic [46:0]   core_z_s;
  logic [92:0]   core_s;
  logic [92:0]   p3_s;
  logic [184:0]  y_nxt_s;

`ifdef OKA_SEQ_CORE_REG_EN
  logic [92:0]   core_q_r;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_M1;
        else           state_nxt_s = ST_IDLE;
      end
      ST_M1:   state_nxt_s = ST_M2;
      ST_M2:   state_nxt_s = ST_M3;
`ifdef OKA_SEQ_CORE_REG_EN
      ST_M3:   state_nxt_s = ST_FLUSH;
      ST_FLUSH: state_nxt_s = ST_DONE;
`else
      ST_M3:   state_nxt_s = ST_DONE;
      ST_FLUSH: state_nxt_s = ST_IDLE;
`endif
      ST_DONE: begin
        if (bus.start) state_nxt_s = ST_M1;
        else           state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/control decode: operand select, register load enables, and the
  // next values of the registered busy/done flags.
  always_comb begin
    cap_en_s   = 1'b0;
    op_sel_s   = SEL_E;
    p1_en_s    = 1'b0;
    p2_en_s    = 1'b0;
    y_en_s     = 1'b0;
    case (state_r)
      ST_IDLE:  cap_en_s = bus.start;
      ST_DONE:  cap_en_s = bus.start;
`ifdef OKA_SEQ_CORE_REG_EN
      // Each partial product lands one cycle after its issuing state.
      ST_M1:    op_sel_s = SEL_E;
      ST_M2:    begin op_sel_s = SEL_O; p1_en_s = 1'b1; end
      ST_M3:    begin op_sel_s = SEL_S; p2_en_s = 1'b1; end
      ST_FLUSH: y_en_s   = 1'b1;
`else
      ST_M1:    begin op_sel_s = SEL_E; p1_en_s = 1'b1; end
      ST_M2:    begin op_sel_s = SEL_O; p2_en_s = 1'b1; end
      ST_M3:    begin op_sel_s = SEL_S; y_en_s  = 1'b1; end
      ST_FLUSH: cap_en_s = 1'b0;
`endif
      default:  cap_en_s = 1'b0;
    endcase

    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_M1, ST_M2, ST_M3, ST_FLUSH: busy_nxt_s = 1'b1;
      ST_DONE:                       done_nxt_s = 1'b1;
      default:                       busy_nxt_s = 1'b0;
    endcase
  end

  // Even/odd coefficient split of the captured operands.
  always_comb begin
    ea_s = 47'd0;
    eb_s = 47'd0;
    oa_s = 47'd0;
    ob_s = 47'd0;
    for (int i = 0; i < 47; i++) begin
      ea_s[i] = a_r[2*i];
      eb_s[i] = b_r[2*i];
    end
    for (int i = 0; i < 46; i++) begin
      oa_s[i] = a_r[2*i+1];
      ob_s[i] = b_r[2*i+1];
    end
  end

  // Core operand mux, selected by the current pass.
  always_comb begin
    core_x_s = ea_s;
    core_z_s = eb_s;
    case (op_sel_s)
      SEL_E: begin core_x_s = ea_s;        core_z_s = eb_s;        end
      SEL_O: begin core_x_s = oa_s;        core_z_s = ob_s;        end
      SEL_S: begin core_x_s = ea_s ^ oa_s; core_z_s = eb_s ^ ob_s; end
      default: begin core_x_s = ea_s;      core_z_s = eb_s;        end
    endcase
  end

  assign core_s = oka_47bit(core_x_s, core_z_s);

`ifdef OKA_SEQ_CORE_REG_EN
  assign p3_s = core_q_r;
`else
  assign p3_s = core_s;
`endif

  assign y_nxt_s = recombine(p1_r, p2_r, p3_s);

  // Operand capture, partial-product and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= 93'd0;
      b_r  <= 93'd0;
      p1_r <= 93'd0;
      p2_r <= 92'd0;
      y_r  <= 185'd0;
    end else begin
      if (cap_en_s) begin
        a_r <= bus.a;
        b_r <= bus.b;
      end
`ifdef OKA_SEQ_CORE_REG_EN
      if (p1_en_s) p1_r <= core_q_r;
      if (p2_en_s) p2_r <= core_q_r[91:0];
`else
      if (p1_en_s) p1_r <= core_s;
      if (p2_en_s) p2_r <= core_s[91:0];
`endif
      if (y_en_s)  y_r  <= y_nxt_s;
    end
  end

`ifdef OKA_SEQ_CORE_REG_EN
  // Pipeline register on the core output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_q_r <= 93'd0;
    end else begin
      core_q_r <= core_s;
    end
  end
`endif

  // Registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.y    = y_r;

endmodule

// File: tb/tb_oka_93bit_seq.sv
// Self-checking bench for oka_93bit_seq: directed vector table, multi-cycle
// corner sequences (back-to-back, start during M2, reset in M2) and random
// operands checked against a shift-and-xor carry-less multiply model.
module tb_oka_93bit_seq;

`ifdef OKA_SEQ_CORE_REG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  oka_93bit_seq_if bus ();

  oka_93bit_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [92:0]  a;
    logic [92:0]  b;
    logic [184:0] y;
  } vec_t;

  function automatic logic [184:0] clmul(input logic [92:0] x, input logic [92:0] z);
    logic [184:0] acc;
    logic [184:0] sh;
    acc = 185'd0;
    sh  = {92'd0, x};
    for (int i = 0; i < 93; i++) begin
      if (z[i]) acc = acc ^ sh;
      sh = sh << 1;
    end
    return acc;
  endfunction

  function automatic logic [92:0] rand93();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[92:0];
  endfunction

  task automatic check(input string name, input logic [184:0] act, input logic [184:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Count done pulses over a number of cycles (sampled 1 after each edge).
  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n++;
    end
  endtask

  // One full operation: issue, scramble inputs while busy, check latency,
  // busy window, product, and that done is a single pulse.
  task automatic mul_check(input string name, input logic [92:0] ta,
                           input logic [92:0] tb, input logic [184:0] exp);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    bus.a = ta; bus.b = tb; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      bus.a = rand93(); bus.b = rand93();
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 185'(cyc), 185'(LAT));
    check({name, " y"}, bus.y, exp);
    check({name, " busy cycles"}, 185'(busy_cnt), 185'(LAT - 1));
    check({name, " busy at done"}, 185'(bus.busy), 185'd0);
    @(posedge clk); #1;
    check({name, " single done"}, 185'(bus.done), 185'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    logic [92:0] pa[3];
    logic [92:0] pb[3];
    logic [92:0] ta;
    logic [92:0] tb;
    logic [184:0] exp_y;
    int          edge_n;
    int          last;
    int          ndone;
    int          nd;
    int          cyc;
    bit          arm;

    vecs[0] = '{"one_one",   93'd1, 93'd1, 185'd1};
    vecs[1] = '{"three_sq",  93'd3, 93'd3, 185'd5};
    vecs[2] = '{"x_sq",      93'd2, 93'd2, 185'd4};
    vecs[3] = '{"top_bits",  93'd1 << 92, 93'd1 << 92, 185'd1 << 184};
    vecs[4] = '{"mid_bits",  93'd1 << 46, 93'd1 << 46, 185'd1 << 92};
    vecs[5] = '{"ones_x1",   {93{1'b1}}, 93'd1, {92'd0, {93{1'b1}}}};
    vecs[6] = '{"zero_a",    93'd0, rand93(), 185'd0};
    vecs[7] = '{"x1_ones",   93'd1, {93{1'b1}}, {92'd0, {93{1'b1}}}};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 93'd0;
    bus.b = 93'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 185'(bus.busy), 185'd0);
    check("reset done", 185'(bus.done), 185'd0);
    check("reset y", bus.y, 185'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      mul_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].y);
    end

    // start held high: three products, done pulses LAT apart.
    for (int i = 0; i < 3; i++) begin
      pa[i] = rand93(); pb[i] = rand93();
    end
    @(negedge clk);
    bus.a = pa[0]; bus.b = pb[0]; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = pa[1]; bus.b = pb[1];
    edge_n = 1; last = 0; ndone = 0; arm = 1'b0;
    while (ndone < 3 && edge_n < 40) begin
      @(posedge clk); #1;
      edge_n++;
      if (arm) begin
        arm = 1'b0;
        if (ndone + 1 < 3) begin
          bus.a = pa[ndone + 1]; bus.b = pb[ndone + 1];
        end
      end
      if (bus.done === 1'b1) begin
        check($sformatf("b2b y%0d", ndone), bus.y, clmul(pa[ndone], pb[ndone]));
        check($sformatf("b2b gap%0d", ndone), 185'(edge_n - last), 185'(LAT));
        last = edge_n;
        ndone++;
        arm = 1'b1;
        if (ndone == 3) bus.start = 1'b0;
      end
    end
    check("b2b count", 185'(ndone), 185'd3);
    bus.start = 1'b0;
    count_dones(8, nd);
    check("b2b no extra done", 185'(nd), 185'd0);

    // start pulsed during M2 is ignored.
    ta = rand93(); tb = rand93(); exp_y = clmul(ta, tb);
    @(negedge clk);
    bus.a = ta; bus.b = tb; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = rand93(); bus.b = rand93();
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 3;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("m2 start latency", 185'(cyc), 185'(LAT));
    check("m2 start y", bus.y, exp_y);
    count_dones(10, nd);
    check("m2 start no extra done", 185'(nd), 185'd0);

    // Reset asserted in M2 aborts the operation.
    @(negedge clk);
    bus.a = rand93() | 93'd1; bus.b = rand93() | 93'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort y", bus.y, 185'd0);
    check("abort busy", 185'(bus.busy), 185'd0);
    check("abort done", 185'(bus.done), 185'd0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(8, nd);
    check("abort no done", 185'(nd), 185'd0);
    ta = rand93(); tb = rand93();
    mul_check("after abort", ta, tb, clmul(ta, tb));

    // Random operands against the model, with random idle gaps.
    for (int i = 0; i < 1500; i++) begin
      ta = rand93(); tb = rand93();
      if (i % 7 == 3) ta = ta & (93'd1 << $urandom_range(0, 92));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mul_check($sformatf("rand%0d", i), ta, tb, clmul(ta, tb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
